// File: rtl/pipe_stage_reg_pkg.sv
// Shared state encodings for the two-entry pipeline stage register.
// Occupancy is the raw state code, so the CPU control path can decode it directly.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] state_occupancy(input state_t s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_FULL: return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Wide data register with load enable and synchronous clear; holds all channels as one word.
module pipe_data_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry valid/ready pipeline stage (main + skid) giving full throughput with a
// registered, Out_Ready-independent In_Ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic                      In_Valid,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    output logic                      In_Ready,
    output logic                      Out_Valid,
    output logic [CHANNELS*WIDTH-1:0] Out_Data,
    input  logic                      Out_Ready,
    output logic [1:0]                Occupancy
);

    localparam int DW = CHANNELS * WIDTH;

    state_t          state;
    logic            in_fire;
    logic            out_fire;
    logic            main_load;
    logic            skid_load;
    logic [DW-1:0]   main_d;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;

    assign Out_Valid = (state != ST_EMPTY);
    assign In_Ready  = (state != ST_FULL) && !Flush;
    assign Occupancy = state_occupancy(state);
    assign Out_Data  = main_q;

    assign in_fire  = In_Valid && In_Ready;
    assign out_fire = Out_Valid && Out_Ready;

    // Data moves are suppressed under Flush so the registers keep their contents.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = In_Data;
        if (!Flush) begin
            case (state)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) state <= ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state <= ST_FULL;
                    end else if (!in_fire && out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: if (out_fire) state <= ST_ONE;
                default: state <= ST_EMPTY;
            endcase
        end
    end

    pipe_data_reg #(.WIDTH(DW)) u_main (
        .clk   (CLK),
        .clear (Reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.WIDTH(DW)) u_skid (
        .clk   (CLK),
        .clear (Reset),
        .load  (skid_load),
        .d     (In_Data),
        .q     (skid_q)
    );

endmodule
